// File: rtl/spi_pkg.sv
// Shared types and defaults for the SPI slave receiver.
package spi_pkg;

  localparam int unsigned DefDataW = 8;

  typedef enum logic [1:0] {
    StIdle,
    StRecv,
    StDone
  } state_e;

endpackage

// File: rtl/spi_sync.sv
// N-stage single-bit synchronizer with synchronous active-high clear.
module spi_sync #(
  parameter int unsigned STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] ff_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      ff_q <= '0;
    end else begin
      ff_q[0] <= d;
      for (int i = 1; i < STAGES; i++) begin
        ff_q[i] <= ff_q[i-1];
      end
    end
  end

  assign q = ff_q[STAGES-1];

endmodule

// File: rtl/spi_slave_rx.sv
// SPI mode-0 slave receiver, MSB-first, oversampled by clk.
// Define SPI_SLAVE_MISO_EN to add the tx_data/miso transmit path.
module spi_slave_rx
  import spi_pkg::*;
#(
  parameter int unsigned DATA_W      = DefDataW,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sclk,
  input  logic              cs,
  input  logic              mosi,
  output logic [DATA_W-1:0] dout,
  output logic              done,
  output logic              frame_err,
`ifdef SPI_SLAVE_MISO_EN
  input  logic [DATA_W-1:0] tx_data,
  output logic              miso,
`endif
  output logic              busy
);

  localparam int unsigned CntW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CntW-1:0] LastBit = CntW'(DATA_W - 1);

  logic sclk_s, cs_s, mosi_s;
  logic sclk_q, cs_q;
  logic sclk_rise, cs_fall, cs_rise;

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic [DATA_W-1:0] dout_q, dout_d;
  logic              done_q, done_d;
  logic              err_q, err_d;

  spi_sync #(.STAGES(SYNC_STAGES)) u_sync_sclk (.clk(clk), .rst(rst), .d(sclk), .q(sclk_s));
  spi_sync #(.STAGES(SYNC_STAGES)) u_sync_cs   (.clk(clk), .rst(rst), .d(cs),   .q(cs_s));
  spi_sync #(.STAGES(SYNC_STAGES)) u_sync_mosi (.clk(clk), .rst(rst), .d(mosi), .q(mosi_s));

  // cs history clears to 0, so a cs already low at reset release never looks like a falling edge.
  assign sclk_rise = sclk_s & ~sclk_q;
  assign cs_fall   = ~cs_s & cs_q;
  assign cs_rise   = cs_s & ~cs_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    shift_d = shift_q;
    dout_d  = dout_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    unique case (state_q)
      StIdle: begin
        cnt_d = '0;
        if (cs_fall) state_d = StRecv;
      end
      StRecv: begin
        if (cs_rise) begin
          err_d   = (cnt_q != '0);
          cnt_d   = '0;
          state_d = StIdle;
        end else if (sclk_rise && !cs_s) begin
          shift_d = (shift_q << 1) | DATA_W'(mosi_s);
          if (cnt_q == LastBit) begin
            cnt_d   = '0;
            state_d = StDone;
          end else begin
            cnt_d = cnt_q + CntW'(1);
          end
        end
      end
      StDone: begin
        dout_d  = shift_q;
        done_d  = 1'b1;
        state_d = cs_s ? StIdle : StRecv;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sclk_q  <= 1'b0;
      cs_q    <= 1'b0;
      state_q <= StIdle;
      cnt_q   <= '0;
      shift_q <= '0;
      dout_q  <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      sclk_q  <= sclk_s;
      cs_q    <= cs_s;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      shift_q <= shift_d;
      dout_q  <= dout_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign dout      = dout_q;
  assign done      = done_q;
  assign frame_err = err_q;
  assign busy      = (state_q != StIdle);

`ifdef SPI_SLAVE_MISO_EN
  logic              sclk_fall;
  logic [DATA_W-1:0] tx_q, tx_d;

  assign sclk_fall = ~sclk_s & sclk_q;

  // The falling edge trailing a frame's last bit sees cnt_q == 0 and must not eat the new MSB.
  always_comb begin
    tx_d = tx_q;
    if (state_q == StIdle && cs_fall) begin
      tx_d = tx_data;
    end else if (state_q == StDone && !cs_s) begin
      tx_d = tx_data;
    end else if (state_q == StRecv && sclk_fall && !cs_s && cnt_q != '0) begin
      tx_d = tx_q << 1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) tx_q <= '0;
    else     tx_q <= tx_d;
  end

  assign miso = (state_q != StIdle) & tx_q[DATA_W-1];
`endif

endmodule

// File: tb/tb_spi_slave_rx.sv
// Directed self-checking bench for spi_slave_rx with a dout scoreboard.
module tb_spi_slave_rx;

  localparam int unsigned DW = 8;
  localparam int unsigned SS = 2;

  logic          clk = 1'b0;
  logic          rst, sclk, cs, mosi;
  logic [DW-1:0] dout;
  logic          done, frame_err, busy;
  logic          miso_w;
`ifdef SPI_SLAVE_MISO_EN
  logic [DW-1:0] tx_data;
  logic          miso;
  assign miso_w = miso;
`else
  assign miso_w = 1'b0;
`endif

  int n_cmp = 0;
  int n_err = 0;
  int n_done = 0;
  int n_ferr = 0;
  logic [DW-1:0] exp_q[$];

  always #5 clk = ~clk;

  spi_slave_rx #(.DATA_W(DW), .SYNC_STAGES(SS)) dut (
    .clk      (clk),
    .rst      (rst),
    .sclk     (sclk),
    .cs       (cs),
    .mosi     (mosi),
    .dout     (dout),
    .done     (done),
    .frame_err(frame_err),
`ifdef SPI_SLAVE_MISO_EN
    .tx_data  (tx_data),
    .miso     (miso),
`endif
    .busy     (busy)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every done pulse must match the next queued frame.
  always @(negedge clk) begin
    logic [DW-1:0] e;
    if (frame_err) n_ferr++;
    if (done) begin
      n_done++;
      if (exp_q.size() > 0) e = exp_q.pop_front();
      else                  e = 'x;
      check("dout_on_done", 32'(dout), 32'(e));
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed timeout, required completion");
    $fatal(1, "watchdog");
  end

  task automatic gap(input int n);
    repeat (n) @(negedge clk);
  endtask

  // One sclk period: 5 clk low then 5 clk high; miso sampled just before the rise.
  task automatic spi_bit(input logic b, input bit want_done, output logic so);
    int lat;
    lat  = 0;
    mosi = b;
    gap(5);
    so   = miso_w;
    sclk = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      @(negedge clk);
      if (done && lat == 0) lat = i;
    end
    sclk = 1'b0;
    if (want_done) begin
      n_cmp++;
      assert (lat >= 1 && lat <= int'(SS) + 2) else begin
        n_err++;
        $error("FAIL done_latency: observed %0d cycles, required 1..%0d", lat, SS + 2);
      end
    end
  endtask

  task automatic send_byte(input logic [DW-1:0] b, input bit want_done, output logic [DW-1:0] so);
    logic s;
    for (int i = DW - 1; i >= 0; i--) begin
      spi_bit(b[i], want_done && (i == 0), s);
      so[i] = s;
    end
  endtask

  initial begin
    int d0, e0;
    logic [DW-1:0] so;
    logic s;
    rst = 1'b1; cs = 1'b1; sclk = 1'b0; mosi = 1'b0;
`ifdef SPI_SLAVE_MISO_EN
    tx_data = '0;
`endif
    gap(3);
    check("rst_dout", 32'(dout), 0);
    check("rst_done", 32'(done), 0);
    check("rst_frame_err", 32'(frame_err), 0);
    check("rst_busy", 32'(busy), 0);
    rst = 1'b0;
    gap(5);

    // Single frame 0xA5
    d0 = n_done; e0 = n_ferr;
    cs = 1'b0; gap(10);
    check("a5_busy_high", 32'(busy), 1);
    exp_q.push_back(8'hA5);
    send_byte(8'hA5, 1'b1, so);
    gap(5);
    check("a5_done_count", 32'(n_done - d0), 1);
    check("a5_dout", 32'(dout), 32'h A5);
    cs = 1'b1; gap(10);
    check("a5_busy_low", 32'(busy), 0);
    check("a5_no_frame_err", 32'(n_ferr - e0), 0);

    // Back-to-back frames under one cs window
    d0 = n_done; e0 = n_ferr;
    cs = 1'b0; gap(10);
    exp_q.push_back(8'h3C);
    exp_q.push_back(8'hC3);
    send_byte(8'h3C, 1'b1, so);
    send_byte(8'hC3, 1'b1, so);
    gap(5);
    check("b2b_done_count", 32'(n_done - d0), 2);
    check("b2b_dout", 32'(dout), 32'hC3);
    cs = 1'b1; gap(10);
    check("b2b_no_frame_err", 32'(n_ferr - e0), 0);

    // Aborted frame after a good 0x12
    cs = 1'b0; gap(10);
    exp_q.push_back(8'h12);
    send_byte(8'h12, 1'b1, so);
    gap(5); cs = 1'b1; gap(10);
    d0 = n_done; e0 = n_ferr;
    cs = 1'b0; gap(10);
    for (int i = 0; i < 5; i++) spi_bit(1'b1, 1'b0, s);
    gap(5); cs = 1'b1; gap(10);
    check("abort_frame_err", 32'(n_ferr - e0), 1);
    check("abort_no_done", 32'(n_done - d0), 0);
    check("abort_dout_kept", 32'(dout), 32'h12);
    check("abort_busy_low", 32'(busy), 0);

    // Reset mid-frame, then cs held low must not start a frame
    cs = 1'b0; gap(10);
    d0 = n_done; e0 = n_ferr;
    spi_bit(1'b1, 1'b0, s); spi_bit(1'b0, 1'b0, s);
    spi_bit(1'b1, 1'b0, s); spi_bit(1'b1, 1'b0, s);
    gap(2);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_dout", 32'(dout), 0);
    check("midrst_done", 32'(done), 0);
    check("midrst_frame_err", 32'(frame_err), 0);
    check("midrst_busy", 32'(busy), 0);
    gap(1);
    rst = 1'b0;
    gap(10);
    send_byte(8'hFF, 1'b0, so);
    gap(5);
    check("midrst_no_pulses", 32'((n_done - d0) + (n_ferr - e0)), 0);
    check("stale_cs_busy_low", 32'(busy), 0);
    cs = 1'b1; gap(10);
    cs = 1'b0; gap(10);
    exp_q.push_back(8'h81);
    send_byte(8'h81, 1'b1, so);
    gap(5); cs = 1'b1; gap(10);
    check("post_rst_dout", 32'(dout), 32'h81);

    // sclk activity with cs high
    d0 = n_done;
    send_byte(8'h6B, 1'b0, so);
    gap(10);
    check("cs_high_no_done", 32'(n_done - d0), 0);
    check("cs_high_busy", 32'(busy), 0);
    check("cs_high_dout", 32'(dout), 32'h81);

`ifdef SPI_SLAVE_MISO_EN
    tx_data = 8'h5A;
    check("miso_idle_low", 32'(miso_w), 0);
    cs = 1'b0; gap(10);
    exp_q.push_back(8'h00);
    send_byte(8'h00, 1'b1, so);
    check("miso_bits", 32'(so), 32'h5A);
    gap(5); cs = 1'b1; gap(10);
    check("miso_after_frame", 32'(miso_w), 0);
`endif

    check("scoreboard_drained", 32'(exp_q.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
